bcd_seq_ctrl: RTL and testbench

Sequential controller that converts a multi-digit packed-BCD word from the board switches into binary, one digit per clock, using a shared multiply-by-ten/accumulate step. It accepts a start request, runs a fixed-length digit sequence, flags any non-decimal nibble, and presents a registered binary result with a one-cycle completion pulse. It sits between the switch/key input stage and the LED/display output stage, replacing per-width combinational lookup converters.

---
 rtl/bcd_seq_pkg.sv | 17 +
 rtl/bcd_digit_mac.sv | 14 +
 rtl/bcd_seq_ctrl.sv | 86 ++++++++
 tb/tb_bcd_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_pkg.sv
// bcd_seq_pkg: shared state encoding, digit limit and result-width helper for the BCD sequencer
package bcd_seq_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam int BCD_MAX_DIGIT = 9;
  // smallest width w with 2^w > 10^digits, so the largest decimal value stays below all ones
  function automatic int min_bin_w(input int digits);
    longint lim;
    int w;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    for (w = 1; (longint'(1) << w) <= lim; w++) begin
    end
    return w;
  endfunction
endpackage

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: combinational acc*10 + d step with a non-decimal digit flag
module bcd_digit_mac
  import bcd_seq_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic [BIN_W-1:0] i_acc,
  input  logic [3:0]       i_d,
  output logic [BIN_W-1:0] o_sum,
  output logic             o_inv
);
  assign o_sum = (i_acc << 3) + (i_acc << 1) + {{(BIN_W-4){1'b0}}, i_d};
  assign o_inv = i_d > 4'(BCD_MAX_DIGIT);
endmodule

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: digit-serial packed-BCD to binary converter with start/busy/done handshake
module bcd_seq_ctrl
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                START,
  input  logic [4*DIGITS-1:0] BCD_IN,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [BIN_W-1:0]    BIN_OUT
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  if (DIGITS < 1 || DIGITS > 4 || BIN_W < min_bin_w(DIGITS)) begin : g_bad_param
    $error("bcd_seq_ctrl: DIGITS must be 1..4 and BIN_W wide enough for 10^DIGITS-1");
  end

  logic [1:0]          r_state;
  logic [4*DIGITS-1:0] r_sr;
  logic [BIN_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic                r_err_out;
  logic [BIN_W-1:0]    r_bin;
  logic [3:0]          w_digit;
  logic [BIN_W-1:0]    w_acc_nxt;
  logic                w_inv;
  logic                w_err_nxt;
  logic                w_last;

  assign w_digit   = r_sr[4*DIGITS-1 -: 4];
  assign w_err_nxt = r_err | w_inv;
  assign w_last    = r_cnt == CNT_W'(1);

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .i_acc(r_acc),
    .i_d  (w_digit),
    .o_sum(w_acc_nxt),
    .o_inv(w_inv)
  );

  // FSM: load on START in IDLE, consume one digit per cycle, publish result on the last digit
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_err_out <= 1'b0;
      r_bin     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (START) begin
          r_sr    <= BCD_IN;
          r_acc   <= '0;
          r_err   <= 1'b0;
          r_cnt   <= CNT_W'(DIGITS);
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_acc <= w_acc_nxt;
          r_err <= w_err_nxt;
          r_sr  <= r_sr << 4;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_bin     <= w_err_nxt ? '1 : w_acc_nxt;
            r_err_out <= w_err_nxt;
            r_state   <= S_FIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY    = r_state != S_IDLE;
  assign DONE    = r_state == S_FIN;
  assign ERR     = r_err_out;
  assign BIN_OUT = r_bin;
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: scoreboard bench; stimulus queues expected results, a monitor checks each DONE
module tb_bcd_seq_ctrl;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               start;
  } exp_t;

  logic              clk;
  logic              RESET_N;
  logic              START;
  logic [11:0]       BCD_IN;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [BIN_W-1:0]  BIN_OUT;

  exp_t q[$];
  exp_t e;
  int   cyc;
  int   total;
  int   passed;
  int   done_cnt;
  int   d0;
  int   s0;
  logic prev_done;

  bcd_seq_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLOCK_50(clk),
    .RESET_N (RESET_N),
    .START   (START),
    .BCD_IN  (BCD_IN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR),
    .BIN_OUT (BIN_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  // monitor: every DONE must match the oldest queued expectation
  always @(negedge clk) begin
    if (RESET_N) begin
      if (prev_done) chk("busy_after_done", int'(BUSY), 0);
      if (DONE) begin
        done_cnt++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got BIN_OUT=%0d expected no DONE", BIN_OUT);
        end else begin
          e = q.pop_front();
          chk("bin_out", int'(BIN_OUT), int'(e.bin));
          chk("err", int'(ERR), int'(e.err));
          chk("latency", cyc - e.start, DIGITS);
          chk("busy_in_fin", int'(BUSY), 1);
        end
      end
    end
    prev_done = RESET_N && DONE;
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (BUSY) begin
      total++;
      $display("FAIL wait_idle: BUSY still 1 after 40 cycles, expected 0");
    end
  endtask

  task automatic conv(input logic [11:0] bcd, input logic [BIN_W-1:0] eb, input logic ee);
    @(negedge clk);
    BCD_IN = bcd;
    START  = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{eb, ee, cyc});
    START = 1'b0;
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc = 0; total = 0; passed = 0; done_cnt = 0; prev_done = 1'b0;
    RESET_N = 1'b0;
    START   = 1'(($urandom));
    BCD_IN  = 12'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      START  = 1'($urandom);
      BCD_IN = 12'($urandom);
    end
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_bin", int'(BIN_OUT), 0);
    START = 1'b0;
    @(negedge clk);
    RESET_N = 1'b1;

    conv(12'h123, 10'h07B, 1'b0);
    conv(12'h999, 10'h3E7, 1'b0);
    conv(12'h000, 10'h000, 1'b0);
    conv(12'h1A5, 10'h3FF, 1'b1);
    conv(12'h019, 10'h013, 1'b0);

    // BCD_IN change and START pulse while busy must be ignored
    d0 = done_cnt;
    @(negedge clk);
    BCD_IN = 12'h456;
    START  = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{10'h1C8, 1'b0, cyc});
    START = 1'b0;
    @(negedge clk);
    BCD_IN = 12'h789;
    START  = 1'b1;
    @(negedge clk);
    START = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);

    // START held high: back-to-back conversions every DIGITS+2 cycles
    @(negedge clk);
    BCD_IN = 12'h250;
    START  = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    for (int i = 0; i < 3; i++) q.push_back('{10'h0FA, 1'b0, s0 + i * (DIGITS + 2)});
    repeat (2 * (DIGITS + 2)) @(posedge clk);
    #1;
    START = 1'b0;
    wait_idle();
    @(negedge clk);

    // asynchronous reset two cycles into a conversion aborts it with no DONE
    d0 = done_cnt;
    @(negedge clk);
    START = 1'b1;
    @(posedge clk);
    #1;
    START = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_bin", int'(BIN_OUT), 0);
    chk("abort_err", int'(ERR), 0);
    repeat (2) @(posedge clk);
    #1;
    RESET_N = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("idle_after_abort", int'(BUSY), 0);

    conv(12'h123, 10'h07B, 1'b0);
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
